// File: rtl/mont_adder_seq_pkg.sv
// rtl/mont_adder_seq_pkg.sv - shared types and constants for the Montgomery adder sequencer
package mont_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ITER,
        RED,
        SUB,
        FIN,
        ERR
    } state_t;

    // Phase value that freezes the adder operand pipeline.
    localparam logic [3:0] PHASE_HOLD = 4'd8;
    // Last active slice of a six-phase reduction/subtract pass.
    localparam logic [3:0] PHASE_LAST = 4'd5;
    // Width of one carry-propagate slice in the adder datapath.
    localparam int SLICE_W = 104;

endpackage

// File: rtl/mont_adder_seq_if.sv
// rtl/mont_adder_seq_if.sv - command and adder-control bundle for the sequencer
interface mont_adder_seq_if #(
    parameter int IW = 8
);
    // command side
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    // adder status
    logic          c_zero;
    logic          c_one;
    logic          c_two;
    logic          c_three;
    logic          subtract_finished;
    // adder controls
    logic          adder_clear;
    logic          c_doubleshift;
    logic          subtract;
    logic [3:0]    phase;
    logic [3:0]    m_sel;
    logic          b_shift;
    logic [IW-1:0] iter_idx;

    modport master (
        input  start, c_zero, c_one, c_two, c_three, subtract_finished,
        output busy, done, error, adder_clear, c_doubleshift, subtract,
               phase, m_sel, b_shift, iter_idx
    );

    modport slave (
        output start, c_zero, c_one, c_two, c_three, subtract_finished,
        input  busy, done, error, adder_clear, c_doubleshift, subtract,
               phase, m_sel, b_shift, iter_idx
    );

endinterface

// File: rtl/mont_adder_seq_phase_ctr.sv
// rtl/mont_adder_seq_phase_ctr.sv - 0..5 wrapping slice counter with hold value, shared by RED and SUB
module mont_phase_ctr
    import mont_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_hold,
    input  logic       i_load,
    input  logic       i_adv,
    output logic [3:0] o_phase,
    output logic       o_last
);

    logic [3:0] r_phase;

    // Hold wins over load, load over advance; any out-of-range value wraps to 0 so 6, 7, 9+ never appear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PHASE_HOLD;
        end else if (i_hold) begin
            r_phase <= PHASE_HOLD;
        end else if (i_load) begin
            r_phase <= 4'd0;
        end else if (i_adv) begin
            r_phase <= (r_phase >= PHASE_LAST) ? 4'd0 : r_phase + 4'd1;
        end
    end

    assign o_phase = r_phase;
    assign o_last  = (r_phase == PHASE_LAST);

endmodule

// File: rtl/mont_adder_seq.sv
// rtl/mont_adder_seq.sv - sequencer stepping the carry-save Montgomery adder through one modular multiply
module mont_adder_seq
    import mont_pkg::*;
#(
    parameter int NUM_ITER = 128,
    parameter int MAX_SUB  = 3,
    parameter int IW       = 8
) (
    input  logic               clk,
    input  logic               rst,
    mont_adder_seq_if.master   bus
);

    localparam int            PW        = (MAX_SUB < 2) ? 1 : $clog2(MAX_SUB + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(NUM_ITER - 1);
    localparam logic [PW-1:0] PASS_MAX  = PW'(MAX_SUB);

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic          r_adder_clear;
    logic          r_dshift;
    logic          r_subtract;
    logic [IW-1:0] r_iter_idx;
    logic [PW-1:0] r_pass_cnt;

    logic          w_iter_last;
    logic [PW-1:0] w_pass_next;
    logic          w_pass_limit;
    logic          w_ph_hold;
    logic          w_ph_load;
    logic          w_ph_adv;
    logic [3:0]    w_phase;
    logic          w_ph_last;
    logic          w_sub_end;

    assign w_iter_last  = (r_iter_idx == ITER_LAST);
    assign w_pass_next  = r_pass_cnt + 1'b1;
    assign w_pass_limit = (w_pass_next == PASS_MAX);
    // A subtract pass ends the operation either on success or when the pass budget is spent.
    assign w_sub_end    = w_ph_last && (bus.subtract_finished || w_pass_limit);

    mont_phase_ctr u_phase_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_ph_hold),
        .i_load  (w_ph_load),
        .i_adv   (w_ph_adv),
        .o_phase (w_phase),
        .o_last  (w_ph_last)
    );

    // Slice counter steering: start at 0 entering RED and SUB, step through each pass, park at hold on exit.
    always_comb begin
        w_ph_hold = 1'b0;
        w_ph_load = 1'b0;
        w_ph_adv  = 1'b0;
        case (r_state)
            ITER: w_ph_load = w_iter_last;
            RED: begin
                if (w_ph_last) w_ph_load = 1'b1;
                else           w_ph_adv  = 1'b1;
            end
            SUB: begin
                if (w_sub_end) w_ph_hold = 1'b1;
                else           w_ph_adv  = 1'b1;
            end
            default: ;
        endcase
    end

    // Main sequencer: state and every registered control output move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_adder_clear <= 1'b0;
            r_dshift      <= 1'b0;
            r_subtract    <= 1'b0;
            r_iter_idx    <= '0;
            r_pass_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state       <= CLEAR;
                        r_busy        <= 1'b1;
                        r_error       <= 1'b0;
                        r_adder_clear <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_state       <= ITER;
                    r_adder_clear <= 1'b0;
                    r_dshift      <= 1'b1;
                    r_iter_idx    <= '0;
                end
                ITER: begin
                    if (w_iter_last) begin
                        r_state    <= RED;
                        r_dshift   <= 1'b0;
                        r_iter_idx <= '0;
                    end else begin
                        r_iter_idx <= r_iter_idx + 1'b1;
                    end
                end
                RED: begin
                    if (w_ph_last) begin
                        r_state    <= SUB;
                        r_subtract <= 1'b1;
                        r_pass_cnt <= '0;
                    end
                end
                SUB: begin
                    if (w_ph_last) begin
                        r_pass_cnt <= w_pass_next;
                        if (bus.subtract_finished) begin
                            r_state    <= FIN;
                            r_done     <= 1'b1;
                            r_subtract <= 1'b0;
                        end else if (w_pass_limit) begin
                            r_state    <= ERR;
                            r_done     <= 1'b1;
                            r_error    <= 1'b1;
                            r_subtract <= 1'b0;
                        end
                    end
                end
                FIN, ERR: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_pass_cnt <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error         = r_error;
    assign bus.adder_clear   = r_adder_clear;
    assign bus.c_doubleshift = r_dshift;
    assign bus.b_shift       = r_dshift;
    assign bus.subtract      = r_subtract;
    assign bus.phase         = w_phase;
    assign bus.iter_idx      = r_iter_idx;
    // Quotient digit is passed straight through so the adder sees it in the same iteration.
    assign bus.m_sel         = (r_state == ITER) ?
                               {bus.c_three, bus.c_two, bus.c_one, bus.c_zero} : 4'd0;

endmodule
